press_classifier: RTL and testbench
===================================

Name: press_classifier

Overview:
- Downstream consumer of the button clean-up stage; takes its one-cycle `clean` press pulses.
- Classifies each press gesture as a single press or a double press, using a programmable inter-press window.
- Keeps a running press count for display or diagnostics.
- Output event pulses drive the next control layer, e.g. mode select and counter up/down.

Parameters:
- WINDOW, 1500000: max cycles after the first press in which a second press makes a double (300 ms at 5 MHz); must be >= 2.
- GUARD, 500000: holdoff cycles after a double, during which presses are not classified; must be >= 1.
- COUNT_W, 8: width of the press counter.

Ports:
- clk5  in  1  system clock, 5 MHz.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- press  in  1  one-cycle press pulse from the clean-up stage; never asserted on two consecutive cycles.
- clr  in  1  synchronous clear of press_count.
- single_evt  out  1  one-cycle pulse: single press recognised.
- double_evt  out  1  one-cycle pulse: double press recognised.
- press_count  out  COUNT_W  total presses seen since reset or clr; wraps.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timer=0, single_evt=0, double_evt=0, press_count=0, busy=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT2, GUARD.
- IDLE:
  - press -> WAIT2, timer cleared to 0.
- WAIT2:
  - Timer increments each cycle.
  - press while timer <= WINDOW-1 -> double_evt=1 next cycle; go to GUARD, timer cleared.
  - No press and timer == WINDOW-1 -> single_evt=1 next cycle; go to IDLE.
  - Press in the final WAIT2 cycle (timer == WINDOW-1) counts as a double; press wins over expiry.
- Timing (press at cycle t in IDLE):
  - WAIT2 occupies cycles t+1 .. t+WINDOW.
  - A second press at any cycle t+1 .. t+WINDOW gives double_evt at (second press cycle + 1).
  - Otherwise single_evt at t+WINDOW+1, with state IDLE in that same cycle.
- GUARD:
  - Lasts exactly GUARD cycles, then IDLE.
  - Presses here are counted but ignored for classification; they do not start a new gesture.
- Event exclusivity: single_evt and double_evt are never high together. Each is high for exactly one cycle per gesture.
- busy = (state != IDLE), registered with the state.
- press_count:
  - Increments on every press, in any state.
  - Wraps from 2^COUNT_W-1 to 0.
  - clr=1 zeroes it; clr and press in the same cycle -> press_count=1.
- Reset mid-gesture: immediate return to IDLE; no pending event is emitted after reset releases.
- Timer width: $clog2(max(WINDOW, GUARD)). Compare values are computed at elaboration; no runtime arithmetic overflow is possible.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE=2'b00, WAIT2=2'b01, GUARD=2'b10; 2'b11 recovers to IDLE.
  - Default timing constants: CLK_HZ=5000000, WINDOW_MS=300, GUARD_MS=100.
- One sub-module, gesture_timer: clear/enable up-counter with a parameterised terminal-count flag. Reused for the WINDOW and GUARD phases by comparing against the per-state limit.
- Press counter and FSM stay in press_classifier.

Test Plan (WINDOW=8, GUARD=4, COUNT_W=4):
1. Hold reset=0 for 3 cycles, then release -> all outputs 0, busy=0; assert reset=0 during WAIT2 -> busy=0 immediately, no event after release.
2. Single press at cycle 10 -> busy high cycles 11-18; single_evt high only at cycle 19; double_evt never; press_count=1.
3. Presses at 10 and 14 -> double_evt high only at 15; GUARD 15-18; busy low at 19; no single_evt; press_count=2.
4. Window boundaries:
   - Presses at 10 and 18 -> double_evt at 19.
   - Presses at 10 and 19 -> single_evt at 19 and a new gesture starts; single_evt again at 28.
5. Presses at 10, 14, 16 (third press in GUARD) -> one double_evt at 15; no further event; press_count=3.
6. Counter boundaries:
   - 15 spaced presses then one more -> press_count 15 then wraps to 0.
   - clr and press in the same cycle -> press_count=1.
   - clr alone -> 0.

Source files
------------

// File: rtl/press_classifier_pkg.sv
// Shared types and timing defaults for the press classifier.
// States, default window/guard lengths and a small elaboration helper.
package press_classifier_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT2 = 2'b01,
        S_GUARD = 2'b10
    } state_t;

    localparam int CLK_HZ    = 5000000;
    localparam int WINDOW_MS = 300;
    localparam int GUARD_MS  = 100;

    localparam int WINDOW_CYC = (CLK_HZ / 1000) * WINDOW_MS;
    localparam int GUARD_CYC  = (CLK_HZ / 1000) * GUARD_MS;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/press_classifier_if.sv
// Press/clear inputs and classified-event outputs of the classifier.
// master drives presses and observes events; slave is the classifier.
interface press_classifier_if #(
    parameter int COUNT_W = 8
);
    logic               press;
    logic               clr;
    logic               single_evt;
    logic               double_evt;
    logic [COUNT_W-1:0] press_count;
    logic               busy;

    modport master (
        output press, clr,
        input  single_evt, double_evt, press_count, busy
    );

    modport slave (
        input  press, clr,
        output single_evt, double_evt, press_count, busy
    );
endinterface

// File: rtl/press_classifier_gesture_timer.sv
// Clear/enable up-counter with a terminal-count flag against a
// selectable last value; clear has priority over enable.
module gesture_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_last);
endmodule

// File: rtl/press_classifier.sv
// Classifies clean press pulses into single/double gestures with a
// post-double holdoff, and counts every press.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int WINDOW  = WINDOW_CYC,
    parameter int GUARD   = GUARD_CYC,
    parameter int COUNT_W = 8
) (
    input  logic         clk5,
    input  logic         reset,
    press_classifier_if.slave bus
);
    localparam int TW = $clog2(max_i(WINDOW, GUARD));
    localparam logic [TW-1:0] W_LAST = TW'(WINDOW - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GUARD - 1);

    state_t             r_state;
    logic               r_single;
    logic               r_double;
    logic               r_busy;
    logic [COUNT_W-1:0] r_cnt;

    logic          w_tclr;
    logic          w_ten;
    logic          w_tc;
    logic [TW-1:0] w_last;

    // Timer restarts on every phase change and idles at zero in IDLE
    always_comb begin
        w_last = (r_state == S_GUARD) ? G_LAST : W_LAST;
        w_ten  = (r_state != S_IDLE);
        w_tclr = 1'b1;
        case (r_state)
            S_WAIT2: w_tclr = bus.press | w_tc;
            S_GUARD: w_tclr = w_tc;
            default: w_tclr = 1'b1;
        endcase
    end

    gesture_timer #(
        .W(TW)
    ) u_timer (
        .clk    (clk5),
        .rst_n  (reset),
        .i_clr  (w_tclr),
        .i_en   (w_ten),
        .i_last (w_last),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.press) begin
                        r_state <= S_WAIT2;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT2: begin
                    // a press on the last window cycle still wins
                    if (bus.press) begin
                        r_double <= 1'b1;
                        r_state  <= S_GUARD;
                    end else if (w_tc) begin
                        r_single <= 1'b1;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                S_GUARD: begin
                    if (w_tc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (bus.clr) begin
            r_cnt <= bus.press ? COUNT_W'(1) : '0;
        end else if (bus.press) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.single_evt  = r_single;
    assign bus.double_evt  = r_double;
    assign bus.busy        = r_busy;
    assign bus.press_count = r_cnt;
endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed gesture table, reset and counter
// corners, then random presses against a deadline-based reference model.
module tb_press_classifier;
    localparam int WINDOW = 8;
    localparam int GUARD  = 4;
    localparam int CW     = 4;
    localparam int NCYC   = 40;
    localparam int NRAND  = 1500;

    logic clk5  = 1'b0;
    logic reset = 1'b0;

    always #5 clk5 = ~clk5;

    press_classifier_if #(.COUNT_W(CW)) bus ();

    press_classifier #(
        .WINDOW  (WINDOW),
        .GUARD   (GUARD),
        .COUNT_W (CW)
    ) dut (
        .clk5  (clk5),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef logic [NCYC-1:0] mask_t;

    typedef struct {
        string name;
        int    p1;
        int    p2;
        int    p3;
        mask_t s_m;
        mask_t d_m;
        mask_t b_m;
        int    cnt;
    } vec_t;

    vec_t vt[6];

    // reference model: gesture deadlines as plain cycle numbers
    int   m_first;
    int   m_guard_end;
    logic m_single;
    logic m_double;
    logic m_busy;
    int   m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_m(input string name, input mask_t act,
                         input mask_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mask_t rng(input int lo, input int hi);
        mask_t m = '0;
        for (int i = 0; i < NCYC; i++)
            if (i >= lo && i <= hi) m[i] = 1'b1;
        return m;
    endfunction

    function automatic mask_t bitc(input int i);
        return rng(i, i);
    endfunction

    task automatic model_reset();
        m_first     = -1;
        m_guard_end = -1;
        m_single    = 1'b0;
        m_double    = 1'b0;
        m_busy      = 1'b0;
        m_cnt       = 0;
    endtask

    // inputs seen during cycle cyc -> expected outputs in cycle cyc+1
    task automatic model_step(input bit p, input bit c, input int cyc);
        m_single = 1'b0;
        m_double = 1'b0;
        if (m_first >= 0) begin
            if (p) begin
                m_double    = 1'b1;
                m_guard_end = cyc + GUARD;
                m_first     = -1;
            end else if (cyc == m_first + WINDOW) begin
                m_single = 1'b1;
                m_first  = -1;
            end
        end else if (cyc > m_guard_end && p) begin
            m_first = cyc;
        end
        m_busy = (m_first >= 0) || (cyc + 1 <= m_guard_end);
        m_cnt  = c ? int'(p) : (m_cnt + int'(p)) % (1 << CW);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        bus.press = 1'b0;
        bus.clr   = 1'b0;
        repeat (3) @(posedge clk5);
        #1;
        reset = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk5);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        mask_t s = '0;
        mask_t d = '0;
        mask_t b = '0;
        do_reset();
        for (int k = 0; k < NCYC; k++) begin
            s[k] = bus.single_evt;
            d[k] = bus.double_evt;
            b[k] = bus.busy;
            bus.press = (k == v.p1) || (k == v.p2) || (k == v.p3);
            tick();
        end
        bus.press = 1'b0;
        chk_m({v.name, " single"}, s, v.s_m);
        chk_m({v.name, " double"}, d, v.d_m);
        chk_m({v.name, " busy"}, b, v.b_m);
        chk({v.name, " count"}, 32'(bus.press_count), 32'(v.cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   seen;
        bit   p;
        bit   prev;
        bit   c;
        int   lim;

        vt[0] = '{"single", 10, -1, -1, bitc(19), '0,
                  rng(11, 18), 1};
        vt[1] = '{"double", 10, 14, -1, '0, bitc(15),
                  rng(11, 18), 2};
        vt[2] = '{"last_win", 10, 18, -1, '0, bitc(19),
                  rng(11, 22), 2};
        vt[3] = '{"past_win", 10, 19, -1, bitc(19) | bitc(28), '0,
                  rng(11, 18) | rng(20, 27), 2};
        vt[4] = '{"in_guard", 10, 14, 16, '0, bitc(15),
                  rng(11, 18), 3};
        vt[5] = '{"first_win", 10, 12, -1, '0, bitc(13),
                  rng(11, 16), 2};

        // reset held, then reset asserted in WAIT2
        reset     = 1'b0;
        bus.press = 1'b0;
        bus.clr   = 1'b0;
        repeat (3) @(posedge clk5);
        #1;
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst single", 32'(bus.single_evt), 0);
        chk("rst double", 32'(bus.double_evt), 0);
        chk("rst count", 32'(bus.press_count), 0);
        reset = 1'b1;
        tick();
        chk("rel busy", 32'(bus.busy), 0);
        bus.press = 1'b1;
        tick();
        bus.press = 1'b0;
        repeat (3) tick();
        chk("wait2 busy", 32'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async busy", 32'(bus.busy), 0);
        chk("async count", 32'(bus.press_count), 0);
        repeat (2) @(posedge clk5);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            seen += int'(bus.single_evt) + int'(bus.double_evt)
                  + int'(bus.busy);
            tick();
        end
        chk("post rst quiet", 32'(seen), 0);

        foreach (vt[i]) run_vec(vt[i]);

        // counter wrap and clear
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.press = 1'b1;
            tick();
            bus.press = 1'b0;
            tick();
        end
        chk("count 15", 32'(bus.press_count), 15);
        bus.press = 1'b1;
        tick();
        bus.press = 1'b0;
        chk("count wrap", 32'(bus.press_count), 0);
        tick();
        bus.press = 1'b1;
        tick();
        bus.press = 1'b0;
        tick();
        chk("count pre clr", 32'(bus.press_count), 1);
        bus.press = 1'b1;
        bus.clr   = 1'b1;
        tick();
        bus.press = 1'b0;
        bus.clr   = 1'b0;
        chk("clr+press", 32'(bus.press_count), 1);
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr alone", 32'(bus.press_count), 0);

        // random presses against the reference model
        do_reset();
        model_reset();
        prev = 1'b0;
        for (int cyc = 0; cyc < NRAND; cyc++) begin
            lim = (cyc < NRAND / 2) ? 5 : 14;
            p = !prev && ($urandom_range(0, lim) == 0);
            c = ($urandom_range(0, 39) == 0);
            prev = p;
            bus.press = p;
            bus.clr   = c;
            model_step(p, c, cyc);
            tick();
            chk("rnd single", 32'(bus.single_evt), 32'(m_single));
            chk("rnd double", 32'(bus.double_evt), 32'(m_double));
            chk("rnd busy", 32'(bus.busy), 32'(m_busy));
            chk("rnd count", 32'(bus.press_count), 32'(m_cnt));
        end
        bus.press = 1'b0;
        bus.clr   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
